mem_port_arbiter: RTL and testbench

Parametrised arbiter that shares the single external memory port (address, 2-bit op, 512-bit common data bus) among `NUM_CH` requesters: instruction fetch, data memory stage, and further clients such as DMA or audio output. It sits between the pipeline stages and the memory/DMA interface. It serialises transactions, tracks the one outstanding access, routes the returned line to its owner, and produces per-channel stall signals. It generalises the fixed two-way fetch/memory-stage address mux, adding arbitration, write data, and a response timeout.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter_picker.sv | 39 +++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the external memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned MAX_CH = 8;

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b10,
      OP_RSV   = 2'b11
   } mem_op_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus of the memory port arbiter.
// slave = arbiter view, master = requesters plus memory model.
interface mem_port_arbiter_if #(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned ADDRW  = 32,
   parameter int unsigned INW    = 512
);
   logic [NUM_CH-1:0]       req;
   logic [2*NUM_CH-1:0]     req_op;
   logic [ADDRW*NUM_CH-1:0] req_addr;
   logic [INW*NUM_CH-1:0]   req_wdata;
   logic                    mem_ready;
   logic                    rd_valid;
   logic [INW-1:0]          common_data_bus_in;
   logic [ADDRW-1:0]        mem_address;
   logic [1:0]              op;
   logic [INW-1:0]          mem_wdata;
   logic [NUM_CH-1:0]       gnt;
   logic [NUM_CH-1:0]       resp_valid;
   logic [INW-1:0]          resp_data;
   logic                    resp_err;
   logic [NUM_CH-1:0]       stall;

   modport slave (
      input  req, req_op, req_addr, req_wdata, mem_ready, rd_valid, common_data_bus_in,
      output mem_address, op, mem_wdata, gnt, resp_valid, resp_data, resp_err, stall
   );

   modport master (
      output req, req_op, req_addr, req_wdata, mem_ready, rd_valid, common_data_bus_in,
      input  mem_address, op, mem_wdata, gnt, resp_valid, resp_data, resp_err, stall
   );
endinterface

// File: rtl/mem_port_arbiter_picker.sv
// Circular priority encoder: first eligible channel at or after start_idx.
// Fixed priority uses start_idx = 0.
module arb_picker
   import mem_arb_pkg::*;
#(
   parameter  int unsigned NUM_CH = 3,
   localparam int unsigned IDXW   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] eligible,
   input  logic [IDXW-1:0]   start_idx,
   output logic [NUM_CH-1:0] win_onehot,
   output logic [IDXW-1:0]   win_idx,
   output logic              any_valid
);
   logic            found;
   int unsigned     pos;
   logic [IDXW-1:0] pos_idx;

   always_comb begin
      win_onehot = '0;
      win_idx    = '0;
      any_valid  = |eligible;
      found      = 1'b0;
      pos        = 0;
      pos_idx    = '0;
      for (int unsigned k = 0; k < MAX_CH; k++) begin
         if (k < NUM_CH) begin
            pos = 32'(start_idx) + k;
            if (pos >= NUM_CH) pos = pos - NUM_CH;
            pos_idx = IDXW'(pos);
            if (!found && eligible[pos_idx]) begin
               found               = 1'b1;
               win_onehot[pos_idx] = 1'b1;
               win_idx             = pos_idx;
            end
         end
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port among NUM_CH requesters, one transaction outstanding.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NUM_CH   = 3,
   parameter int unsigned ADDRW    = 32,
   parameter int unsigned INW      = 512,
   parameter int unsigned TIMEOUTW = 8
) (
   input logic           clk,
   input logic           rst_n,
   mem_port_arbiter_if.slave bus
);
   localparam int unsigned IDXW = $clog2(NUM_CH);

   arb_state_t          state_q, state_d;
   logic [IDXW-1:0]     owner_q, owner_d;
   logic [1:0]          op_q, op_d;
   logic [ADDRW-1:0]    addr_q, addr_d;
   logic [INW-1:0]      wdata_q, wdata_d;
   logic [TIMEOUTW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [NUM_CH-1:0]   gnt_q, gnt_d, resp_valid_q, resp_valid_d;
   logic [INW-1:0]      resp_data_q, resp_data_d;
   logic                resp_err_q, resp_err_d;

   logic [NUM_CH-1:0]   eligible, win_onehot;
   logic [IDXW-1:0]     win_idx, start_idx;
   logic                any_eligible, timeout;

   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < NUM_CH; i++)
         eligible[i] = bus.req[i] && (bus.req_op[2*i +: 2] != OP_NONE);
   end

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic [IDXW-1:0] rr_last_q, rr_last_d;

   always_comb begin
      rr_last_d = rr_last_q;
      if (state_q == IDLE && any_eligible) rr_last_d = win_idx;
      start_idx = (rr_last_q == IDXW'(NUM_CH - 1)) ? '0 : rr_last_q + IDXW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) rr_last_q <= IDXW'(NUM_CH - 1);
      else        rr_last_q <= rr_last_d;
   end
`else
   assign start_idx = '0;
`endif

   arb_picker #(.NUM_CH(NUM_CH)) u_picker (
      .eligible   (eligible),
      .start_idx  (start_idx),
      .win_onehot (win_onehot),
      .win_idx    (win_idx),
      .any_valid  (any_eligible)
   );

   // Terminal count is the cycle in which the counter would reach all-ones.
   assign cnt_inc = cnt_q + TIMEOUTW'(1);
   assign timeout = &cnt_inc;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (any_eligible) state_d = ISSUE;
         ISSUE:   if (bus.mem_ready) state_d = (op_q == OP_WRITE) ? IDLE : WAIT;
         WAIT:    if (bus.rd_valid || timeout) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      owner_d      = owner_q;
      op_d         = op_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      gnt_d        = '0;
      resp_valid_d = '0;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
      unique case (state_q)
         IDLE: begin
            if (any_eligible) begin
               owner_d = win_idx;
               op_d    = bus.req_op[2*win_idx +: 2];
               addr_d  = bus.req_addr[ADDRW*win_idx +: ADDRW];
               wdata_d = bus.req_wdata[INW*win_idx +: INW];
               gnt_d   = win_onehot;
            end
         end
         ISSUE: begin
            if (bus.mem_ready) begin
               if (op_q == OP_WRITE) begin
                  resp_valid_d[owner_q] = 1'b1;
                  resp_err_d            = 1'b0;
                  resp_data_d           = '0;
                  op_d                  = OP_NONE;
               end else begin
                  cnt_d = '0;
               end
            end
         end
         WAIT: begin
            if (bus.rd_valid) begin
               resp_valid_d[owner_q] = 1'b1;
               resp_err_d            = 1'b0;
               resp_data_d           = bus.common_data_bus_in;
               op_d                  = OP_NONE;
            end else if (timeout) begin
               resp_valid_d[owner_q] = 1'b1;
               resp_err_d            = 1'b1;
               resp_data_d           = '0;
               op_d                  = OP_NONE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: op_d = OP_NONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner_q      <= '0;
         op_q         <= OP_NONE;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         gnt_q        <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         owner_q      <= owner_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         gnt_q        <= gnt_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign bus.op          = op_q;
   assign bus.mem_address = addr_q;
   assign bus.mem_wdata   = wdata_q;
   assign bus.gnt         = gnt_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_data   = resp_data_q;
   assign bus.resp_err    = resp_err_q;
   assign bus.stall       = bus.req & ~resp_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: transaction-level requester/memory model with randomized traffic.
module tb_mem_port_arbiter;
   localparam int NCH    = 3;
   localparam int AW     = 32;
   localparam int DW     = 512;
   localparam int TW     = 4;
   localparam int TO_CYC = (1 << TW) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.NUM_CH(NCH), .ADDRW(AW), .INW(DW)) bus ();

   mem_port_arbiter #(.NUM_CH(NCH), .ADDRW(AW), .INW(DW), .TIMEOUTW(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   bit            pend      [NCH];
   bit            mask_only [NCH];
   logic [1:0]    p_op      [NCH];
   logic [AW-1:0] p_addr    [NCH];
   logic [DW-1:0] p_wdata   [NCH];
   int            rr_last;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rand_line();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [1:0] rand_op();
      int s;
      s = $urandom_range(0, 2);
      return (s == 0) ? 2'b01 : (s == 1) ? 2'b10 : 2'b11;
   endfunction

   function automatic bit any_pend();
      for (int c = 0; c < NCH; c++) if (pend[c]) return 1'b1;
      return 1'b0;
   endfunction

   // Arbitration rule: lowest pending index, or first pending after last winner.
   function automatic int model_winner();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= NCH; k++) if (pend[(rr_last + k) % NCH]) return (rr_last + k) % NCH;
`else
      for (int c = 0; c < NCH; c++) if (pend[c]) return c;
`endif
      return -1;
   endfunction

   task automatic new_req(input int c, input logic [1:0] opv, input logic [AW-1:0] addr);
      pend[c]    = 1'b1;
      p_op[c]    = opv;
      p_addr[c]  = addr;
      p_wdata[c] = rand_line();
   endtask

   task automatic apply_reqs();
      for (int c = 0; c < NCH; c++) begin
         bus.req[c]                 = pend[c] | mask_only[c];
         bus.req_op[2*c +: 2]       = pend[c] ? p_op[c] : 2'b00;
         bus.req_addr[AW*c +: AW]   = p_addr[c];
         bus.req_wdata[DW*c +: DW]  = p_wdata[c];
      end
   endtask

   // One full transaction. rd_lat = 0 means memory never returns data.
   task automatic run_txn(input int mem_delay, input int rd_lat, input bit drop_early,
                          input logic [DW-1:0] rdata, output int winner);
      int w, waited;
      logic [NCH-1:0] exp_vec, req_now;
      w = model_winner();
      winner = w;
      req_now = bus.req;
      exp_vec = '0;
      if (w >= 0) exp_vec[w] = 1'b1;
      waited = 0;
      do begin step(); waited++; end while (bus.gnt == '0 && waited < 20);
      tests++;
      if (bus.gnt !== exp_vec || waited != 1) begin
         fails++;
         $display("FAIL gnt: got %b after %0d cycles, expected %b after 1", bus.gnt, waited, exp_vec);
      end
      if (w < 0 || bus.gnt == '0) return;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_last = w;
`endif
      tests++;
      if (bus.op !== p_op[w] || bus.mem_address !== p_addr[w] || bus.mem_wdata !== p_wdata[w]) begin
         fails++;
         $display("FAIL issue_bus: op %b addr %h, expected op %b addr %h (wdata match %0d)",
                  bus.op, bus.mem_address, p_op[w], p_addr[w], bus.mem_wdata === p_wdata[w]);
      end
      tests++;
      if (bus.stall !== req_now) begin
         fails++;
         $display("FAIL stall_gnt: got %b expected %b", bus.stall, req_now);
      end
      if (drop_early) bus.req[w] = 1'b0;
      for (int i = 0; i < mem_delay; i++) begin
         bus.rd_valid = 1'($urandom_range(0, 1));
         bus.common_data_bus_in = rand_line();
         step();
         tests++;
         if (bus.op !== p_op[w] || bus.mem_address !== p_addr[w] || bus.mem_wdata !== p_wdata[w] ||
             bus.resp_valid !== '0 || bus.gnt !== '0) begin
            fails++;
            $display("FAIL issue_hold: op %b addr %h resp_valid %b gnt %b, expected op %b addr %h, no pulses",
                     bus.op, bus.mem_address, bus.resp_valid, bus.gnt, p_op[w], p_addr[w]);
         end
      end
      bus.rd_valid  = 1'b0;
      bus.mem_ready = 1'b1;
      step();
      bus.mem_ready = 1'b0;
      if (p_op[w] == 2'b10) begin
         tests++;
         if (bus.resp_valid !== exp_vec || bus.resp_err !== 1'b0 || bus.op !== 2'b00) begin
            fails++;
            $display("FAIL write_resp: resp_valid %b err %b op %b, expected %b 0 00",
                     bus.resp_valid, bus.resp_err, bus.op, exp_vec);
         end
      end else begin
         int quiet;
         quiet = (rd_lat == 0) ? TO_CYC - 1 : rd_lat - 1;
         for (int i = 0; i < quiet; i++) begin
            tests++;
            if (bus.resp_valid !== '0 || bus.op !== p_op[w]) begin
               fails++;
               $display("FAIL wait_hold: resp_valid %b op %b at wait cycle %0d, expected 0 and op %b",
                        bus.resp_valid, bus.op, i + 1, p_op[w]);
            end
            step();
         end
         if (rd_lat != 0) begin
            bus.rd_valid = 1'b1;
            bus.common_data_bus_in = rdata;
         end
         step();
         bus.rd_valid = 1'b0;
         tests++;
         if (bus.resp_valid !== exp_vec || bus.resp_err !== (rd_lat == 0) ||
             bus.resp_data !== ((rd_lat == 0) ? '0 : rdata) || bus.op !== 2'b00) begin
            fails++;
            $display("FAIL read_resp: resp_valid %b err %b op %b data %h, expected %b err %0d data %h",
                     bus.resp_valid, bus.resp_err, bus.op, bus.resp_data[63:0], exp_vec,
                     rd_lat == 0, (rd_lat == 0) ? 64'h0 : rdata[63:0]);
         end
      end
      tests++;
      if (bus.stall !== (bus.req & ~exp_vec)) begin
         fails++;
         $display("FAIL stall_resp: got %b expected %b", bus.stall, bus.req & ~exp_vec);
      end
      pend[w] = 1'b0;
      apply_reqs();
   endtask

   task automatic drain();
      int w;
      for (int i = 0; i < NCH && any_pend(); i++) run_txn(0, 1, 1'b0, rand_line(), w);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      rr_last = NCH - 1;
   endtask

   task automatic test_reset();
      for (int c = 0; c < NCH; c++) begin
         pend[c] = 1'b0; mask_only[c] = 1'b0; p_op[c] = 2'b00; p_addr[c] = '0; p_wdata[c] = '0;
      end
      apply_reqs();
      bus.mem_ready = 1'b0;
      bus.rd_valid  = 1'b0;
      bus.common_data_bus_in = '0;
      rst_n = 1'b0;
      step(); step(); step();
      tests++;
      if (bus.op !== 2'b00 || bus.mem_address !== '0 || bus.mem_wdata !== '0) begin
         fails++;
         $display("FAIL reset_bus: op %b addr %h, expected 00 0", bus.op, bus.mem_address);
      end
      tests++;
      if (bus.gnt !== '0 || bus.resp_valid !== '0 || bus.resp_err !== 1'b0 || bus.resp_data !== '0) begin
         fails++;
         $display("FAIL reset_resp: gnt %b resp_valid %b err %b, expected all zero",
                  bus.gnt, bus.resp_valid, bus.resp_err);
      end
      rst_n = 1'b1;
      rr_last = NCH - 1;
      step();
   endtask

   task automatic test_single_read();
      int w;
      new_req(1, 2'b01, 32'h40);
      apply_reqs();
      run_txn(0, 3, 1'b0, {64{8'hA5}}, w);
   endtask

   task automatic test_back_to_back();
      int order [4];
      int w;
      do_reset();
      for (int c = 0; c < NCH; c++) new_req(c, 2'b01, 32'($urandom));
      apply_reqs();
      for (int n = 0; n < 4; n++) begin
         run_txn(0, 1, 1'b0, rand_line(), w);
         order[n] = w;
         if (n < 3) begin
            new_req(w, 2'b01, 32'($urandom));
            apply_reqs();
         end
      end
      for (int n = 0; n < 4; n++) begin
         tests++;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         if (order[n] != n % NCH) begin
            fails++;
            $display("FAIL rr_order[%0d]: winner %0d expected %0d", n, order[n], n % NCH);
         end
`else
         if (order[n] != 0) begin
            fails++;
            $display("FAIL fixed_order[%0d]: winner %0d expected 0", n, order[n]);
         end
`endif
      end
      drain();
   endtask

   task automatic test_write_stall();
      int w;
      new_req(2, 2'b10, 32'h1234_5678);
      apply_reqs();
      run_txn(5, 1, 1'b0, '0, w);
   endtask

   task automatic test_timeout();
      int w;
      new_req(0, 2'b01, 32'hDEAD_0000);
      apply_reqs();
      run_txn(1, 0, 1'b0, '0, w);
      new_req(1, 2'b11, 32'hBEEF_0000);
      apply_reqs();
      run_txn(0, 2, 1'b0, rand_line(), w);
      new_req(2, 2'b01, 32'hCAFE_0000);
      apply_reqs();
      run_txn(0, TO_CYC, 1'b0, rand_line(), w);
   endtask

   task automatic test_op_mask_and_drop();
      int w;
      mask_only[0] = 1'b1;
      new_req(2, 2'b01, 32'h80);
      apply_reqs();
      run_txn(0, 2, 1'b1, rand_line(), w);
      mask_only[0] = 1'b0;
      apply_reqs();
   endtask

   task automatic test_reset_mid();
      int w;
      logic [NCH-1:0] exp_vec;
      new_req(2, 2'b01, 32'h100);
      apply_reqs();
      step();
      exp_vec = '0; exp_vec[2] = 1'b1;
      tests++;
      if (bus.gnt !== exp_vec) begin
         fails++;
         $display("FAIL rst_mid_gnt: got %b expected %b", bus.gnt, exp_vec);
      end
      bus.mem_ready = 1'b1;
      step();
      bus.mem_ready = 1'b0;
      step();
      tests++;
      if (bus.op !== 2'b01) begin
         fails++;
         $display("FAIL rst_mid_wait: op %b expected 01", bus.op);
      end
      new_req(0, 2'b01, 32'h200);
      new_req(1, 2'b10, 32'h300);
      apply_reqs();
      rst_n = 1'b0;
      bus.rd_valid = 1'b1;
      bus.common_data_bus_in = rand_line();
      step();
      tests++;
      if (bus.op !== 2'b00 || bus.resp_valid !== '0 || bus.gnt !== '0) begin
         fails++;
         $display("FAIL rst_mid_abort: op %b resp_valid %b gnt %b, expected all zero",
                  bus.op, bus.resp_valid, bus.gnt);
      end
      rst_n = 1'b1;
      bus.rd_valid = 1'b0;
      rr_last = NCH - 1;
      run_txn(0, 1, 1'b0, rand_line(), w);
      drain();
   endtask

   task automatic test_random();
      int w, sel, lat;
      for (int n = 0; n < 40; n++) begin
         for (int c = 0; c < NCH; c++)
            if (!pend[c] && $urandom_range(0, 1) == 1) new_req(c, rand_op(), 32'($urandom));
         if (!any_pend()) new_req($urandom_range(0, NCH - 1), rand_op(), 32'($urandom));
         for (int c = 0; c < NCH; c++) mask_only[c] = !pend[c] && ($urandom_range(0, 3) == 0);
         apply_reqs();
         sel = $urandom_range(0, 9);
         lat = (sel == 0) ? 0 : (sel == 1) ? TO_CYC : $urandom_range(1, 4);
         run_txn($urandom_range(0, 3), lat, $urandom_range(0, 3) == 0, rand_line(), w);
      end
      for (int c = 0; c < NCH; c++) mask_only[c] = 1'b0;
      drain();
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_read();
      test_back_to_back();
      test_write_stall();
      test_timeout();
      test_op_mask_and_drop();
      test_reset_mid();
      test_random();
      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
